// File: rtl/posit_check_pkg.sv
// Shared definitions for the posit stream checker.
//   state_e      : checker run state (IDLE, RUN, DRAIN, DONE)
//   DEF_N        : default posit word width
//   DEF_DEPTH    : default expected-value FIFO depth
//   DEF_TIMEOUT  : default watchdog limit in cycles
package posit_check_pkg;

  localparam int unsigned DEF_N       = 8;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/posit_check_fifo.sv
// Synchronous FIFO holding expected posit values.
//   clk, srst : clock, synchronous active-high reset (clears pointers/count)
//   push      : write wdata (ignored when full)
//   pop       : discard head (ignored when empty)
//   wdata     : value to enqueue
//   head      : current head value, valid whenever count != 0; reflects the
//               queue state before this cycle's push
//   count     : number of stored entries, 0..DEPTH
module posit_check_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // The head is consumed in the same cycle the result arrives, so it is read
  // asynchronously from the current read pointer.
  assign head  = mem[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/posit_stream_checker.sv
// Compares a stream of unit results against queued expected posits.
//   aclk, reset            : clock, synchronous active-high reset
//   exp_valid/exp_data     : expected value issued alongside unit operands
//   exp_ready              : FIFO has room
//   res_valid/res_data     : unit result strobe and value
//   tol                    : allowed absolute difference (unsigned bit patterns)
//   finish                 : pulse, no further expected values
//   err_valid/diff/flag    : registered compare result, one cycle after res_valid
//   sample_cnt/mismatch_cnt: saturating compare / mismatch counters
//   max_diff               : largest difference seen
//   underflow/overflow/timeout : sticky error flags
//   state_done             : checking complete
module posit_stream_checker
  import posit_check_pkg::*;
#(
  parameter int unsigned N       = DEF_N,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         exp_valid,
  input  logic [N-1:0] exp_data,
  output logic         exp_ready,
  input  logic         res_valid,
  input  logic [N-1:0] res_data,
  input  logic [N-1:0] tol,
  input  logic         finish,
  output logic         err_valid,
  output logic [N-1:0] err_diff,
  output logic         err_flag,
  output logic [31:0]  sample_cnt,
  output logic [31:0]  mismatch_cnt,
  output logic [N-1:0] max_diff,
  output logic         underflow,
  output logic         overflow,
  output logic         timeout,
  output logic         state_done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] fifo_count;
  logic [N-1:0]  fifo_head;
  logic          fifo_empty, push_open, do_push, do_pop;
  logic [N-1:0]  diff;

  state_e        state_q, state_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          err_valid_q, err_valid_d;
  logic [N-1:0]  err_diff_q, err_diff_d;
  logic          err_flag_q, err_flag_d;
  logic [31:0]   sample_cnt_q, sample_cnt_d;
  logic [31:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic [N-1:0]  max_diff_q, max_diff_d;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;
  logic          timeout_q, timeout_d;

  posit_check_fifo #(
    .W     (N),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (aclk),
    .srst  (reset),
    .push  (do_push),
    .pop   (do_pop),
    .wdata (exp_data),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign exp_ready  = fifo_count < CW'(DEPTH);
  assign fifo_empty = fifo_count == '0;
  assign push_open  = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign do_push    = exp_valid && exp_ready && push_open;
  // Emptiness is judged on the pre-push count, so a push landing in the same
  // cycle cannot satisfy a result.
  assign do_pop     = res_valid && !fifo_empty && (state_q != ST_DONE);
  assign diff       = (fifo_head > res_data) ? (fifo_head - res_data)
                                             : (res_data - fifo_head);

  always_comb begin
    state_d        = state_q;
    wd_d           = wd_q;
    err_valid_d    = do_pop;
    err_diff_d     = err_diff_q;
    err_flag_d     = err_flag_q;
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    max_diff_d     = max_diff_q;
    underflow_d    = underflow_q | (res_valid && !do_pop);
    overflow_d     = overflow_q | (exp_valid && !do_push);
    timeout_d      = timeout_q;

    if (do_pop) begin
      err_diff_d = diff;
      err_flag_d = diff > tol;
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + 32'd1;
      if ((diff > tol) && (mismatch_cnt_q != '1)) mismatch_cnt_d = mismatch_cnt_q + 32'd1;
      if (diff > max_diff_q) max_diff_d = diff;
    end

    // Watchdog only runs while something is outstanding and checking is live.
    if (res_valid || fifo_empty || (state_q == ST_DONE)) wd_d = '0;
    else                                                  wd_d = wd_q + WW'(1);

    case (state_q)
      ST_IDLE: begin
        if (finish)       state_d = ST_DONE;
        else if (do_push) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (finish) state_d = ST_RUN == state_q ? ST_DRAIN : state_q;
      end
      ST_DRAIN: begin
        // Wait for the last compare strobe to clear before declaring completion.
        if (fifo_empty && !err_valid_q) state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase

    if (wd_d == WW'(TIMEOUT)) begin
      timeout_d = 1'b1;
      state_d   = ST_DONE;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wd_q           <= '0;
      err_valid_q    <= 1'b0;
      err_diff_q     <= '0;
      err_flag_q     <= 1'b0;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      max_diff_q     <= '0;
      underflow_q    <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      err_valid_q    <= err_valid_d;
      err_diff_q     <= err_diff_d;
      err_flag_q     <= err_flag_d;
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      max_diff_q     <= max_diff_d;
      underflow_q    <= underflow_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
    end
  end

  assign err_valid    = err_valid_q;
  assign err_diff     = err_diff_q;
  assign err_flag     = err_flag_q;
  assign sample_cnt   = sample_cnt_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign max_diff     = max_diff_q;
  assign underflow    = underflow_q;
  assign overflow     = overflow_q;
  assign timeout      = timeout_q;
  assign state_done   = state_q == ST_DONE;

endmodule

// File: tb/tb_posit_stream_checker.sv
module tb_posit_stream_checker;

  localparam int N       = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic         aclk = 1'b0;
  logic         reset;
  logic         exp_valid, res_valid, finish;
  logic [N-1:0] exp_data, res_data, tol;
  logic         exp_ready, err_valid, err_flag;
  logic [N-1:0] err_diff, max_diff;
  logic [31:0]  sample_cnt, mismatch_cnt;
  logic         underflow, overflow, timeout, state_done;

  posit_stream_checker #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .aclk         (aclk),
    .reset        (reset),
    .exp_valid    (exp_valid),
    .exp_data     (exp_data),
    .exp_ready    (exp_ready),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .tol          (tol),
    .finish       (finish),
    .err_valid    (err_valid),
    .err_diff     (err_diff),
    .err_flag     (err_flag),
    .sample_cnt   (sample_cnt),
    .mismatch_cnt (mismatch_cnt),
    .max_diff     (max_diff),
    .underflow    (underflow),
    .overflow     (overflow),
    .timeout      (timeout),
    .state_done   (state_done)
  );

  always #5 aclk = ~aclk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a queue of outstanding expected values plus the
  // observable bookkeeping the checker is supposed to report.
  logic [N-1:0] q[$];
  int           m_samples, m_mism, m_state, m_wait;
  logic [N-1:0] m_max;
  bit           m_under, m_over, m_tout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_samples = 0; m_mism = 0; m_max = '0;
    m_under = 0; m_over = 0; m_tout = 0;
    m_state = M_IDLE; m_wait = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; exp_valid = 1'b0; res_valid = 1'b0; finish = 1'b0;
    @(posedge aclk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive inputs, advance the model, then check every output.
  task automatic step(input bit ev, input logic [N-1:0] ed, input bit rv,
                      input logic [N-1:0] rd, input bit fin);
    int pre, st_pre;
    bit v_exp, f_exp;
    logic [N-1:0] h, d_exp;
    exp_valid = ev; exp_data = ed; res_valid = rv; res_data = rd; finish = fin;
    pre = q.size(); st_pre = m_state;
    v_exp = 0; f_exp = 0; d_exp = '0;
    if (rv) begin
      if (pre == 0 || st_pre == M_DONE) m_under = 1;
      else begin
        h = q.pop_front();
        d_exp = (h > rd) ? h - rd : rd - h;
        f_exp = d_exp > tol;
        v_exp = 1;
        m_samples++;
        if (f_exp) m_mism++;
        if (d_exp > m_max) m_max = d_exp;
      end
    end
    if (ev) begin
      if (pre < DEPTH && (st_pre == M_IDLE || st_pre == M_RUN)) begin
        q.push_back(ed);
        if (st_pre == M_IDLE) m_state = M_RUN;
      end else m_over = 1;
    end
    if (fin) begin
      if (st_pre == M_IDLE) m_state = M_DONE;
      else if (st_pre == M_RUN) m_state = M_DRAIN;
    end
    if (rv || pre == 0 || st_pre == M_DONE) m_wait = 0;
    else m_wait++;
    if (m_wait == TIMEOUT) begin m_tout = 1; m_state = M_DONE; end

    @(posedge aclk); #1;
    chk("err_valid", 32'(err_valid), 32'(v_exp));
    if (v_exp) begin
      chk("err_diff", 32'(err_diff), 32'(d_exp));
      chk("err_flag", 32'(err_flag), 32'(f_exp));
    end
    chk("sample_cnt", sample_cnt, 32'(m_samples));
    chk("mismatch_cnt", mismatch_cnt, 32'(m_mism));
    chk("max_diff", 32'(max_diff), 32'(m_max));
    chk("underflow", 32'(underflow), 32'(m_under));
    chk("overflow", 32'(overflow), 32'(m_over));
    chk("timeout", 32'(timeout), 32'(m_tout));
    chk("exp_ready", 32'(exp_ready), 32'(q.size() < DEPTH));
    if (m_state != M_DRAIN) chk("state_done", 32'(state_done), 32'(m_state == M_DONE));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 10 && !state_done; i++) step(0, '0, 0, '0, 0);
    chk(tag, 32'(state_done), 32'd1);
    m_state = M_DONE;
  endtask

  initial begin
    exp_data = '0; res_data = '0; tol = '0;

    // Reset state
    do_reset();
    chk("rst_exp_ready", 32'(exp_ready), 32'd1);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_sample_cnt", sample_cnt, 32'd0);
    chk("rst_state_done", 32'(state_done), 32'd0);
    chk("rst_flags", {29'd0, underflow, overflow, timeout}, 32'd0);

    // 16 exact matches at latency 12, then finish
    tol = '0;
    for (int c = 0; c < 28; c++)
      step(c < 16, 8'h40, c >= 12, 8'h40, 0);
    step(0, '0, 0, '0, 1);
    wait_done("lat12_done");
    chk("lat12_samples", sample_cnt, 32'd16);
    chk("lat12_mismatch", mismatch_cnt, 32'd0);
    chk("lat12_maxdiff", 32'(max_diff), 32'd0);

    // Single mismatch beyond tolerance
    do_reset();
    tol = 8'd2;
    step(1, 8'h50, 0, '0, 0);
    step(0, '0, 1, 8'h4C, 0);
    chk("mm_diff", 32'(err_diff), 32'd4);
    chk("mm_flag", 32'(err_flag), 32'd1);
    chk("mm_count", mismatch_cnt, 32'd1);

    // Result with nothing queued; push and pop together on empty FIFO
    do_reset();
    step(0, '0, 1, 8'h11, 0);
    chk("uf_flag", 32'(underflow), 32'd1);
    chk("uf_samples", sample_cnt, 32'd0);
    do_reset();
    step(1, 8'h22, 1, 8'h22, 0);
    chk("uf_same_cycle", 32'(underflow), 32'd1);

    // Fill past depth
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, '0, 0);
    chk("full_ready", 32'(exp_ready), 32'd0);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    step(1, 8'hEE, 0, '0, 0);
    chk("full_ovf", 32'(overflow), 32'd1);

    // Watchdog boundary
    do_reset();
    step(1, 8'h33, 0, '0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, '0, 0, '0, 0);
    chk("wd_before", 32'(timeout), 32'd0);
    step(0, '0, 0, '0, 0);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_done", 32'(state_done), 32'd1);

    // Reset mid-operation discards queued values
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, '0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, '0, 1, 8'h60 + 8'(i), 0);
    chk("rmid_underflow", 32'(underflow), 32'd1);
    chk("rmid_samples", sample_cnt, 32'd0);

    // finish in IDLE, then traffic in DONE
    do_reset();
    step(0, '0, 0, '0, 1);
    chk("idle_finish_done", 32'(state_done), 32'd1);
    step(1, 8'h12, 0, '0, 0);
    step(0, '0, 1, 8'h12, 0);
    chk("done_flags", {30'd0, overflow, underflow}, 32'd3);

    // Randomized traffic against the queue model, then drain
    do_reset();
    tol = 8'($urandom_range(0, 32));
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] hd, rd;
      hd = 8'($urandom);
      rd = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0] + 8'($urandom_range(0, 40)) - 8'd20
                                                       : 8'($urandom);
      step($urandom_range(0, 1) == 1, hd, $urandom_range(0, 1) == 1, rd, 0);
    end
    step(0, '0, 0, '0, 1);
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) step(0, '0, 1, 8'($urandom), 0);
    wait_done("rand_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
